// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, operand-select encodings and the
// default datapath widths used by the issue stage and its forward selectors.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   // ALU op codes (4 bits, must match the ALU decoder)
   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_SLL    = 4'b0010;
   localparam logic [3:0] ALU_SLT    = 4'b0011;
   localparam logic [3:0] ALU_SLTU   = 4'b0100;
   localparam logic [3:0] ALU_XOR    = 4'b0101;
   localparam logic [3:0] ALU_SRL    = 4'b0110;
   localparam logic [3:0] ALU_SRA    = 4'b0111;
   localparam logic [3:0] ALU_OR     = 4'b1000;
   localparam logic [3:0] ALU_PASS_1 = 4'b1001;
   localparam logic [3:0] ALU_AND    = 4'b1010;

   // Operand source selects
   localparam logic A_SEL_RS1 = 1'b0;
   localparam logic A_SEL_PC  = 1'b1;
   localparam logic B_SEL_RS2 = 1'b0;
   localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forward selector: picks MEM result, then WB result, then
// register-file data. Register x0 is never forwarded.
module fwd_sel #(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int RA_W = cpu_pkg::RA_W
) (
   input  logic [RA_W-1:0] src_addr,
   input  logic [XLEN-1:0] rf_data,
   input  logic            mem_we,
   input  logic [RA_W-1:0] mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            wb_we,
   input  logic [RA_W-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] fwd_data
);

   // Priority mux: the younger (MEM) producer wins over WB
   always_comb begin
      fwd_data = rf_data;
      if (mem_we && (mem_rd != '0) && (mem_rd == src_addr)) begin
         fwd_data = mem_data;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == src_addr)) begin
         fwd_data = wb_data;
      end
   end

endmodule

// File: rtl/ex_issue_stage.sv
// Decode-to-execute pipeline register feeding the ALU. Selects operand
// sources, forwards from MEM/WB and interlocks on hazards.
// Build option: ISSUE_FORWARD_EN enables MEM/WB forwarding (load-use is the
// only stall). Without it, operands come from the register file only and any
// MEM/WB match on a used source stalls until that stage retires.
//
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. ready never depends on valid of the same side (in_ready sees in_valid
// only through the hazard term); once out_valid is high, all outputs hold
// until out_ready consumes them or flush/rst kills them.
module ex_issue_stage #(
   parameter int XLEN  = cpu_pkg::XLEN,
   parameter int RA_W  = cpu_pkg::RA_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [RA_W-1:0]  in_rs1_addr,
   input  logic [RA_W-1:0]  in_rs2_addr,
   input  logic [RA_W-1:0]  in_rd_addr,
   input  logic             in_rd_we,
   input  logic [3:0]       in_alu_op,
   input  logic             in_a_sel,
   input  logic             in_b_sel,
   input  logic             mem_we,
   input  logic             mem_is_load,
   input  logic [RA_W-1:0]  mem_rd,
   input  logic [XLEN-1:0]  mem_data,
   input  logic             wb_we,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  operand_a,
   output logic [XLEN-1:0]  operand_b,
   output logic [3:0]       alu_op,
   output logic [RA_W-1:0]  out_rd_addr,
   output logic             out_rd_we,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_store_data,
   output logic [CNT_W-1:0] stall_count
);

   import cpu_pkg::*;

   logic            rs1_used;
   logic            mem_hit_rs1;
   logic            mem_hit_rs2;
   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // rs2 always counts as used so store data is covered
   assign rs1_used    = (in_a_sel == A_SEL_RS1);
   assign mem_hit_rs1 = mem_we && (mem_rd != '0) && (mem_rd == in_rs1_addr);
   assign mem_hit_rs2 = mem_we && (mem_rd != '0) && (mem_rd == in_rs2_addr);

`ifdef ISSUE_FORWARD_EN
   fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
      .src_addr (in_rs1_addr),
      .rf_data  (in_rs1_data),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .fwd_data (fwd_rs1)
   );

   fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
      .src_addr (in_rs2_addr),
      .rf_data  (in_rs2_data),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd),
      .mem_data (mem_data),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .fwd_data (fwd_rs2)
   );

   // Only a load in MEM cannot be forwarded yet (its data is not ready)
   assign hazard = in_valid && mem_is_load &&
                   ((rs1_used && mem_hit_rs1) || mem_hit_rs2);
`else
   logic wb_hit_rs1;
   logic wb_hit_rs2;
   logic unused_fwd;

   assign fwd_rs1    = in_rs1_data;
   assign fwd_rs2    = in_rs2_data;
   assign wb_hit_rs1 = wb_we && (wb_rd != '0) && (wb_rd == in_rs1_addr);
   assign wb_hit_rs2 = wb_we && (wb_rd != '0) && (wb_rd == in_rs2_addr);
   assign unused_fwd = ^{mem_is_load, mem_data, wb_data};

   // Any in-flight producer of a used source stalls until it retires
   assign hazard = in_valid &&
                   ((rs1_used && (mem_hit_rs1 || wb_hit_rs1)) ||
                    mem_hit_rs2 || wb_hit_rs2);
`endif

   assign in_ready = !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Pipeline register: flush beats accept; data holds unless accepting
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         operand_a      <= '0;
         operand_b      <= '0;
         alu_op         <= '0;
         out_rd_addr    <= '0;
         out_rd_we      <= 1'b0;
         out_pc         <= '0;
         out_store_data <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         operand_a      <= (in_a_sel == A_SEL_PC)  ? in_pc  : fwd_rs1;
         operand_b      <= (in_b_sel == B_SEL_IMM) ? in_imm : fwd_rs2;
         out_store_data <= fwd_rs2;
         alu_op         <= in_alu_op;
         out_rd_addr    <= in_rd_addr;
         out_rd_we      <= in_rd_we;
         out_pc         <= in_pc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating count of interlock cycles (flushed cycles are not stalls)
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (hazard && !flush && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: table of single-instruction vectors plus
// hand-written sequences for load-use, backpressure, flush, saturation, reset.
// Works with or without ISSUE_FORWARD_EN defined.
module tb_ex_issue_stage;
   import cpu_pkg::*;

`ifdef ISSUE_FORWARD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif
   localparam int CW = 4;

   logic          clk, rst;
   logic          in_valid, in_ready;
   logic [31:0]   in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]    in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic          in_rd_we;
   logic [3:0]    in_alu_op;
   logic          in_a_sel, in_b_sel;
   logic          mem_we, mem_is_load;
   logic [4:0]    mem_rd;
   logic [31:0]   mem_data;
   logic          wb_we;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic          flush;
   logic          out_valid, out_ready;
   logic [31:0]   operand_a, operand_b, out_pc, out_store_data;
   logic [3:0]    alu_op;
   logic [4:0]    out_rd_addr;
   logic          out_rd_we;
   logic [CW-1:0] stall_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_stall = 0;
   logic [31:0] exp_q[$];

   ex_issue_stage #(.XLEN(32), .RA_W(5), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_alu_op(in_alu_op),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .mem_we(mem_we),
      .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
      .operand_b(operand_b), .alu_op(alu_op), .out_rd_addr(out_rd_addr),
      .out_rd_we(out_rd_we), .out_pc(out_pc), .out_store_data(out_store_data),
      .stall_count(stall_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        a_sel, b_sel;
      logic [3:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rs1_d, rs2_d, pc, imm;
      logic        mem_we, mem_ld;
      logic [4:0]  mem_rd;
      logic [31:0] mem_d;
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_d;
      logic        exp_rdy;
      logic [31:0] exp_a, exp_b, exp_sd;
   } vec_t;

   vec_t tbl[9];

   function automatic vec_t mk(
      logic a_sel, logic b_sel, logic [3:0] op,
      logic [4:0] rs1, logic [31:0] rs1_d, logic [4:0] rs2, logic [31:0] rs2_d,
      logic [4:0] rd, logic [31:0] pc, logic [31:0] imm,
      logic m_we, logic m_ld, logic [4:0] m_rd, logic [31:0] m_d,
      logic w_we, logic [4:0] w_rd, logic [31:0] w_d,
      logic e_rdy, logic [31:0] e_a, logic [31:0] e_b, logic [31:0] e_sd);
      vec_t v;
      v.a_sel = a_sel; v.b_sel = b_sel; v.op = op;
      v.rs1 = rs1; v.rs1_d = rs1_d; v.rs2 = rs2; v.rs2_d = rs2_d;
      v.rd = rd; v.pc = pc; v.imm = imm;
      v.mem_we = m_we; v.mem_ld = m_ld; v.mem_rd = m_rd; v.mem_d = m_d;
      v.wb_we = w_we; v.wb_rd = w_rd; v.wb_d = w_d;
      v.exp_rdy = e_rdy; v.exp_a = e_a; v.exp_b = e_b; v.exp_sd = e_sd;
      return v;
   endfunction

   // scoreboard compare
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bump_stall();
      if (exp_stall < (1 << CW) - 1) exp_stall++;
   endtask

   // driver tasks
   task automatic idle();
      in_valid = 1'b0; mem_we = 1'b0; mem_is_load = 1'b0; wb_we = 1'b0; flush = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      in_valid = 1'b1; in_a_sel = v.a_sel; in_b_sel = v.b_sel; in_alu_op = v.op;
      in_rs1_addr = v.rs1; in_rs1_data = v.rs1_d; in_rs2_addr = v.rs2;
      in_rs2_data = v.rs2_d; in_rd_addr = v.rd; in_rd_we = 1'b1;
      in_pc = v.pc; in_imm = v.imm;
      mem_we = v.mem_we; mem_is_load = v.mem_ld; mem_rd = v.mem_rd; mem_data = v.mem_d;
      wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_d;
   endtask

   // simple instruction: operand_a = rs1 data, operand_b = imm, no producers
   task automatic drive_simple(input logic [4:0] rs1, input logic [31:0] d);
      drive_vec(mk(A_SEL_RS1, B_SEL_IMM, ALU_ADD, rs1, d, 5'd1, 32'h1, 5'd2,
                   32'h300, 32'h1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
   endtask

   // one clock; retire the oldest expected entry if a consume happens here
   task automatic step();
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected_consume", 32'd1, 32'd0);
         else chk("sb_consume_a", operand_a, exp_q.pop_front());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0] = mk(0, 1, ALU_ADD,    5'd3, 32'h5,    5'd1, 32'h11, 5'd10, 32'h40,  32'h7,
                  0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 32'h5, 32'h7, 32'h11);
      tbl[1] = mk(1, 0, ALU_SUB,    5'd9, 32'h9,    5'd2, 32'h22, 5'd11, 32'h100, 32'h0,
                  0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 32'h100, 32'h22, 32'h22);
      tbl[2] = mk(0, 1, ALU_PASS_1, 5'd6, 32'hdead, 5'd1, 32'h1,  5'd12, 32'h44,  32'h123,
                  0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 32'hdead, 32'h123, 32'h1);
      tbl[3] = mk(0, 0, ALU_ADD,    5'd0, 32'h55,   5'd0, 32'h66, 5'd13, 32'h48,  32'h0,
                  1, 0, 5'd0, 32'h77, 1, 5'd0, 32'h88, 1, 32'h55, 32'h66, 32'h66);
      tbl[4] = mk(0, 0, ALU_ADD,    5'd3, 32'h5,    5'd1, 32'h1,  5'd14, 32'h4c,  32'h0,
                  1, 0, 5'd3, 32'h10, 1, 5'd3, 32'h20, FWD, 32'h10, 32'h1, 32'h1);
      tbl[5] = mk(0, 0, ALU_SUB,    5'd0, 32'h44,   5'd1, 32'h1,  5'd15, 32'h50,  32'h0,
                  1, 0, 5'd3, 32'h10, 1, 5'd3, 32'h20, 1, 32'h44, 32'h1, 32'h1);
      tbl[6] = mk(0, 0, ALU_ADD,    5'd1, 32'h1,    5'd5, 32'h3,  5'd16, 32'h54,  32'h0,
                  0, 0, 5'd0, 32'h0,  1, 5'd5, 32'h88, FWD, 32'h1, 32'h88, 32'h88);
      tbl[7] = mk(1, 1, ALU_ADD,    5'd4, 32'h4,    5'd2, 32'h2,  5'd17, 32'h200, 32'h9,
                  1, 1, 5'd4, 32'hbad, 0, 5'd0, 32'h0, 1, 32'h200, 32'h9, 32'h2);
      tbl[8] = mk(0, 0, ALU_SUB,    5'd1, 32'h1,    5'd2, 32'h2,  5'd18, 32'h58,  32'h0,
                  1, 0, 5'd2, 32'h30, 0, 5'd0, 32'h0,  FWD, 32'h1, 32'h30, 32'h30);

      // reset
      rst = 1'b1; out_ready = 1'b0;
      idle();
      drive_simple(5'd0, 32'h0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_operand_a", operand_a, 0);
      chk("rst_operand_b", operand_b, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_store_data", out_store_data, 0);
      chk("rst_rd_addr", out_rd_addr, 0);
      chk("rst_rd_we", out_rd_we, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_stall_count", stall_count, 0);
      @(negedge clk); rst = 1'b0;

      // table-driven single instructions, execute always ready
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive_vec(tbl[i]);
         out_ready = 1'b1;
         #1;
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
         if (!tbl[i].exp_rdy) bump_stall();
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].exp_rdy);
         if (tbl[i].exp_rdy) begin
            chk($sformatf("v%0d_operand_a", i), operand_a, tbl[i].exp_a);
            chk($sformatf("v%0d_operand_b", i), operand_b, tbl[i].exp_b);
            chk($sformatf("v%0d_store_data", i), out_store_data, tbl[i].exp_sd);
            chk($sformatf("v%0d_alu_op", i), alu_op, tbl[i].op);
            chk($sformatf("v%0d_rd_addr", i), out_rd_addr, tbl[i].rd);
            chk($sformatf("v%0d_out_pc", i), out_pc, tbl[i].pc);
         end
      end
      chk("table_stall_count", stall_count, exp_stall);

      // load-use: load to x4 in MEM, consumer reads rs2=x4
      @(negedge clk);
      drive_vec(mk(0, 0, ALU_ADD, 5'd1, 32'h1, 5'd4, 32'h4, 5'd20, 32'h60, 32'h0,
                   1, 1, 5'd4, 32'hbad, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      #1;
      chk("lu_in_ready", in_ready, 0);
      bump_stall();
      @(posedge clk); #1;
      chk("lu_bubble", out_valid, 0);
      chk("lu_stall_count", stall_count, exp_stall);
      @(negedge clk);
      mem_we = 1'b0; mem_is_load = 1'b0;
      wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h99;
`ifdef ISSUE_FORWARD_EN
      #1;
      chk("lu_wb_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("lu_wb_out_valid", out_valid, 1);
      chk("lu_wb_operand_b", operand_b, 32'h99);
      chk("lu_wb_store_data", out_store_data, 32'h99);
`else
      #1;
      chk("lu_wb_in_ready", in_ready, 0);
      bump_stall();
      @(posedge clk); #1;
      chk("lu_wb_out_valid", out_valid, 0);
      @(negedge clk);
      wb_we = 1'b0;
      #1;
      chk("lu_rf_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("lu_rf_out_valid", out_valid, 1);
      chk("lu_rf_operand_b", operand_b, 32'h4);
`endif
      chk("lu_final_stall_count", stall_count, exp_stall);

      // backpressure: hold A for 3 cycles while B waits, then drain in order
      @(negedge clk); idle(); out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      drive_simple(5'd7, 32'hA0);
      #1;
      chk("bp_a_in_ready", in_ready, 1);
      exp_q.push_back(32'hA0);
      step();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_simple(5'd8, 32'hB0);
         out_ready = 1'b0;
         #1;
         chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
         step();
         chk($sformatf("bp_hold%0d_out_valid", k), out_valid, 1);
         chk($sformatf("bp_hold%0d_operand_a", k), operand_a, 32'hA0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready, 1);
      exp_q.push_back(32'hB0);
      step();
      chk("bp_b_operand_a", operand_a, 32'hB0);
      @(negedge clk);
      in_valid = 1'b0;
      step();
      chk("bp_drained_out_valid", out_valid, 0);
      chk("bp_queue_empty", exp_q.size(), 0);

      // flush while holding a valid instruction with a new one offered
      @(negedge clk);
      drive_simple(5'd9, 32'hC0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("fl_c_out_valid", out_valid, 1);
      @(negedge clk);
      drive_simple(5'd10, 32'hD0);
      out_ready = 1'b0; flush = 1'b1;
      #1;
      chk("fl_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("fl_out_valid", out_valid, 0);
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("fl_nothing_accepted", out_valid, 0);
      // flush masks a load-use hazard from the stall count
      @(negedge clk);
      drive_vec(mk(0, 0, ALU_ADD, 5'd1, 32'h1, 5'd4, 32'h4, 5'd20, 32'h60, 32'h0,
                   1, 1, 5'd4, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      flush = 1'b1;
      @(posedge clk); #1;
      chk("fl_hazard_stall_count", stall_count, exp_stall);

      // saturation under a long stall with a held output, then reset mid-stall
      @(negedge clk);
      idle(); out_ready = 1'b1;
      drive_simple(5'd11, 32'hE0);
      @(posedge clk); #1;
      @(negedge clk);
      drive_vec(mk(0, 0, ALU_ADD, 5'd1, 32'h1, 5'd4, 32'h4, 5'd20, 32'h60, 32'h0,
                   1, 1, 5'd4, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0));
      out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         bump_stall();
      end
      #1;
      chk("sat_stall_count", stall_count, exp_stall);
      chk("sat_stall_count_max", stall_count, 4'hF);
      chk("sat_held_operand_a", operand_a, 32'hE0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_stall_count", stall_count, 0);
      chk("rst_mid_operand_a", operand_a, 0);
      @(negedge clk);
      rst = 1'b0; idle();
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
